// File: rtl/vram_port_arbiter.sv
// Shares one single-port character/font BRAM between the VGA fetch path and a CPU port.
// The display always gets the port and its reads are never stalled; the CPU uses the idle cycles.
module vram_port_arbiter #(
   parameter int AW           = 11,
   parameter int DW           = 16,
   parameter int STARVE_LIMIT = 1024
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          disp_re_i,
   input  logic [AW-1:0] disp_addr_i,
   output logic [DW-1:0] disp_data_o,
   output logic          disp_valid_o,
   input  logic          cpu_req_i,
   input  logic          cpu_we_i,
   input  logic [AW-1:0] cpu_addr_i,
   input  logic [DW-1:0] cpu_wdata_i,
   output logic          cpu_ack_o,
   output logic [DW-1:0] cpu_rdata_o,
   output logic          starve_o,
   output logic [AW-1:0] mem_addr_o,
   output logic          mem_we_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] ACK  = 1'b1;

   logic [0:0]    state;
   logic          grant;
   logic          rd_pend;
   logic [DW-1:0] rdata_q;
   logic [CW-1:0] wait_cnt;

   // The CPU only gets the port in an IDLE cycle that the display leaves free.
   assign grant = (state == IDLE) && cpu_req_i && !disp_re_i;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      mem_addr_o = disp_addr_i;
      mem_we_o   = 1'b0;
      if (!disp_re_i && grant) begin
         mem_addr_o = cpu_addr_i;
         mem_we_o   = cpu_we_i;
      end
   end

   assign mem_wdata_o = cpu_wdata_i;
   assign disp_data_o = mem_rdata_i;

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state        <= IDLE;
         rd_pend      <= 1'b0;
         rdata_q      <= '0;
         wait_cnt     <= '0;
         disp_valid_o <= 1'b0;
      end else begin
         disp_valid_o <= disp_re_i;
         case (state)
            IDLE: begin
               if (grant) begin
                  state   <= ACK;
                  rd_pend <= !cpu_we_i;
               end
            end
            default: state <= IDLE;
         endcase
         if (state == ACK && rd_pend) begin
            rdata_q <= mem_rdata_i;
         end
         if (grant) begin
            wait_cnt <= '0;
         end else if (state == IDLE && cpu_req_i && wait_cnt != CW'(STARVE_LIMIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

   assign cpu_ack_o   = (state == ACK);
   // Read data is presented in the ack cycle straight from the BRAM, then held.
   assign cpu_rdata_o = (cpu_ack_o && rd_pend) ? mem_rdata_i : rdata_q;
   assign starve_o    = (wait_cnt == CW'(STARVE_LIMIT));

endmodule
